apb_mem_slave_p: RTL and testbench

Parametrised APB slave memory. It is the successor to the fixed 8-bit/256-entry slave and adds the following:
- configurable data width, address width and depth
- programmable wait states
- PSTRB byte-lane writes
- PSLVERR on out-of-range addresses
- a registered read path driven by an explicit state machine

It sits behind the APB master/bridge as the generic memory-mapped target.

---
 rtl/apb_mem_slave_p.sv | 130 +++++++++++++
 tb/tb_apb_mem_slave_p.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave_p.sv
// Purpose : parametrised APB memory target with byte strobes, wait states and PSLVERR on out-of-range words.
// Latency : PREADY rises in access-phase cycle WAIT_STATES+1; reads are served from a word latched at setup.
// Backpres: PREADY held low while the wait counter runs; dropping PSEL/PENABLE early aborts with no write.
module apb_mem_slave_p #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW  = ADDR_WIDTH - LSB;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WS      = 4'(WAIT_STATES);
  localparam logic [IW:0] DEPTH_W = (IW+1)'(DEPTH);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q;
  logic                  wr_q;
  logic                  err_q;
  logic [AW-1:0]         idx_q;
  logic [DATA_WIDTH-1:0] wdat_q;
  logic [NB-1:0]         strb_q;
  logic [DATA_WIDTH-1:0] rd_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IW-1:0]         idx;
  logic [AW-1:0]         idx_m;
  logic                  err;
  logic                  done;
  logic                  capture;
  logic                  commit;

  // Byte offset bits are dropped; anything at or beyond DEPTH is an error word.
  assign idx   = IW'(PADDR >> LSB);
  assign idx_m = idx[AW-1:0];
  assign err   = ({1'b0, idx} >= DEPTH_W);

  // Transfer completes in the access cycle where the wait counter has run out.
  assign done = (state_q == ACCESS) && (cnt_q == 4'd0);

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge PCLK) begin
    if (PRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode plus the APB response, which depends only on registered state.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    commit  = 1'b0;
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = '0;
    case (state_q)
      IDLE: begin
        // Only a proper setup phase starts a transfer; a bare PENABLE is ignored.
        if (PSEL && !PENABLE) begin
          capture = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        PREADY  = done;
        PSLVERR = done & err_q;
        PRDATA  = (done && !wr_q && !err_q) ? rd_q : '0;
        if (!(PSEL && PENABLE)) begin
          state_d = IDLE;
        end else if (done) begin
          commit  = wr_q & ~err_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the request at setup and count down the programmed wait states.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cnt_q  <= 4'd0;
      rd_q   <= '0;
      wr_q   <= 1'b0;
      err_q  <= 1'b0;
      idx_q  <= '0;
      wdat_q <= '0;
      strb_q <= '0;
    end else if (capture) begin
      cnt_q  <= WS;
      wr_q   <= PWRITE;
      err_q  <= err;
      idx_q  <= idx_m;
      wdat_q <= PWDATA;
      strb_q <= PSTRB;
      rd_q   <= err ? '0 : mem[idx_m];
    end else if ((state_q == ACCESS) && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Byte-lane write on completion; contents survive reset.
  always_ff @(posedge PCLK) begin
    if (!PRESET && commit) begin
      for (int i = 0; i < NB; i++) begin
        if (strb_q[i]) mem[idx_q][8*i +: 8] <= wdat_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_slave_p.sv
// Bench for apb_mem_slave_p: three instances with 0, 3 and 2 wait states, each on its own bus.
// A transaction-level model predicts the response of every cycle from the wait count and a word array.
// A single negedge process compares all three DUTs against those predictions; literal reads pin the model.
module tb_apb_mem_slave_p;

  logic        clk;
  logic        prst    [3];
  logic        psel    [3];
  logic        pen     [3];
  logic        pwr     [3];
  logic [11:0] paddr   [3];
  logic [31:0] pwdata  [3];
  logic [3:0]  pstrb   [3];
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];

  logic        exp_rdy [3];
  logic        exp_err [3];
  logic [31:0] exp_dat [3];
  logic        chk_on;

  logic [31:0] mdl [3][256];

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_mem_slave_p #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (12),
      .DEPTH      (256),
      .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 3 : 2))
    ) u_dut (
      .PCLK   (clk),
      .PRESET (prst[g]),
      .PSEL   (psel[g]),
      .PENABLE(pen[g]),
      .PWRITE (pwr[g]),
      .PADDR  (paddr[g]),
      .PWDATA (pwdata[g]),
      .PSTRB  (pstrb[g]),
      .PRDATA (prdata[g]),
      .PREADY (pready[g]),
      .PSLVERR(pslverr[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
  endfunction

  task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h want %h at %0t", nm, d, act, exp, $time);
    end
  endtask

  // Compare process: every cycle after reset, every DUT against its predicted response.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 3; d++) begin
        check("pready",  d, {31'b0, pready[d]},  {31'b0, exp_rdy[d]});
        check("pslverr", d, {31'b0, pslverr[d]}, {31'b0, exp_err[d]});
        check("prdata",  d, prdata[d], exp_dat[d]);
      end
    end
  end

  task automatic bus_idle(input int d);
    psel[d] = 1'b0;
    pen[d]  = 1'b0;
    exp_rdy[d] = 1'b0;
    exp_err[d] = 1'b0;
    exp_dat[d] = 32'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // One APB transfer. abort_k / rst_k name the access cycle (1-based) in which PSEL is
  // dropped or PRESET is raised; 0 means a normal transfer.
  task automatic xfer(input int d, input bit wr, input logic [11:0] addr,
                      input logic [31:0] wdat, input logic [3:0] strb,
                      input int abort_k, input int rst_k, output logic [31:0] rdat);
    int n;
    int idx;
    bit err;
    n    = ws_of(d);
    idx  = int'(addr >> 2);
    err  = (idx >= 256);
    rdat = 32'h0;
    // setup phase: slave is idle, response all zero
    psel[d] = 1'b1; pen[d] = 1'b0; pwr[d] = wr;
    paddr[d] = addr; pwdata[d] = wdat; pstrb[d] = strb;
    exp_rdy[d] = 1'b0; exp_err[d] = 1'b0; exp_dat[d] = 32'h0;
    @(posedge clk); #1;
    for (int k = 1; k <= n + 1; k++) begin
      // access phase: scramble the payload, the slave must use the captured copy
      pen[d] = 1'b1;
      paddr[d] = addr ^ 12'h004;
      pwdata[d] = ~wdat;
      pstrb[d] = ~strb;
      pwr[d] = ~wr;
      if (k == abort_k) begin
        psel[d] = 1'b0;
        pen[d] = 1'b0;
      end
      if (k == rst_k) prst[d] = 1'b1;
      if (k == n + 1) begin
        exp_rdy[d] = 1'b1;
        exp_err[d] = err;
        exp_dat[d] = (!wr && !err) ? mdl[d][idx] : 32'h0;
        #3;
        rdat = prdata[d];
      end else begin
        exp_rdy[d] = 1'b0;
        exp_err[d] = 1'b0;
        exp_dat[d] = 32'h0;
      end
      @(posedge clk); #1;
      if (k == abort_k || k == rst_k) begin
        prst[d] = 1'b0;
        bus_idle(d);
        return;
      end
    end
    if (wr && !err) begin
      for (int i = 0; i < 4; i++)
        if (strb[i]) mdl[d][idx][8*i +: 8] = wdat[8*i +: 8];
    end
    bus_idle(d);
  endtask

  logic [31:0] r;

  initial begin
    chk_on = 1'b0;
    for (int d = 0; d < 3; d++) begin
      prst[d] = 1'b1; pwr[d] = 1'b0; paddr[d] = 12'h0; pwdata[d] = 32'h0; pstrb[d] = 4'h0;
      bus_idle(d);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) prst[d] = 1'b0;
    chk_on = 1'b1;
    check("reset_pready", 0, {31'b0, pready[0]}, 32'h0);
    check("reset_prdata", 1, prdata[1], 32'h0);

    // zero-wait write then read
    xfer(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 0, r);
    xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, 0, 0, r);
    check("rd_deadbeef", 0, r, 32'hDEADBEEF);
    idle(1);

    // byte strobes
    xfer(0, 1'b1, 12'h020, 32'h11223344, 4'hF, 0, 0, r);
    xfer(0, 1'b1, 12'h020, 32'hAABBCCDD, 4'b0101, 0, 0, r);
    xfer(0, 1'b0, 12'h022, 32'h0, 4'h0, 0, 0, r);
    check("rd_strobe", 0, r, 32'h11BB33DD);
    xfer(0, 1'b1, 12'h020, 32'hFFFFFFFF, 4'h0, 0, 0, r);
    xfer(0, 1'b0, 12'h020, 32'h0, 4'h0, 0, 0, r);
    check("rd_nostrobe", 0, r, 32'h11BB33DD);
    idle(2);

    // three wait states
    xfer(1, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 0, r);
    idle(1);
    xfer(1, 1'b0, 12'h010, 32'h0, 4'h0, 0, 0, r);
    check("rd_ws3", 1, r, 32'hDEADBEEF);
    idle(1);

    // out of range
    xfer(0, 1'b1, 12'h000, 32'h5A5A0000, 4'hF, 0, 0, r);
    xfer(0, 1'b1, 12'h400, 32'h12345678, 4'hF, 0, 0, r);
    xfer(0, 1'b0, 12'h400, 32'h0, 4'h0, 0, 0, r);
    check("rd_oor", 0, r, 32'h0);
    xfer(0, 1'b0, 12'h000, 32'h0, 4'h0, 0, 0, r);
    check("rd_word0", 0, r, 32'h5A5A0000);
    idle(1);

    // abort and reset on the two-wait-state instance
    xfer(2, 1'b1, 12'h030, 32'h01234567, 4'hF, 0, 0, r);
    xfer(2, 1'b0, 12'h030, 32'h0, 4'h0, 0, 0, r);
    check("rd_ws2", 2, r, 32'h01234567);
    xfer(2, 1'b1, 12'h030, 32'hBAD0BAD0, 4'hF, 2, 0, r);
    idle(1);
    xfer(2, 1'b0, 12'h030, 32'h0, 4'h0, 0, 0, r);
    check("rd_after_abort", 2, r, 32'h01234567);
    xfer(2, 1'b1, 12'h030, 32'hCAFEF00D, 4'hF, 0, 1, r);
    check("post_reset_pready", 2, {31'b0, pready[2]}, 32'h0);
    idle(1);
    xfer(2, 1'b0, 12'h030, 32'h0, 4'h0, 0, 0, r);
    check("rd_after_reset", 2, r, 32'h01234567);
    idle(1);

    // back-to-back write then read
    xfer(0, 1'b1, 12'h0FC, 32'hA5A5A5A5, 4'hF, 0, 0, r);
    xfer(0, 1'b0, 12'h0FC, 32'h0, 4'h0, 0, 0, r);
    check("rd_b2b", 0, r, 32'hA5A5A5A5);

    // PENABLE without a setup phase is ignored
    psel[0] = 1'b1; pen[0] = 1'b1; pwr[0] = 1'b1; paddr[0] = 12'h0FC; pwdata[0] = 32'h0; pstrb[0] = 4'hF;
    idle(1);
    bus_idle(0);
    idle(2);
    xfer(0, 1'b0, 12'h0FC, 32'h0, 4'h0, 0, 0, r);
    check("rd_after_pulse", 0, r, 32'hA5A5A5A5);
    idle(2);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
